// File: rtl/pixel_stream_loader.sv
// Frame loader: buffers one N*N frame from a valid/ready stream and replays it on we/data_out, PACE clocks per pixel.
// Latency push->we is two clocks; s_ready drops while the FIFO is full or once the whole frame has been accepted.
module pixel_stream_loader_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == LP_DEPTH);
    assign o_empty = (r_count == '0);
endmodule

module pixel_stream_loader #(
    parameter int N           = 8,
    parameter int pixelWidth  = 8,
    parameter int bitSize     = $clog2(N*N),
    parameter int FIFO_DEPTH  = 4,
    parameter int PACE        = 2,
    parameter int PROC_CYCLES = 320
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_s_valid,
    input  logic [pixelWidth-1:0] i_s_data,
    output logic                  o_s_ready,
    output logic                  o_we,
    output logic [pixelWidth-1:0] o_data_out,
    output logic [bitSize:0]      o_pix_index,
    output logic                  o_busy,
    output logic                  o_frame_done
);
    localparam int PACE_W = (PACE > 1) ? $clog2(PACE) : 1;
    localparam int PROC_W = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;
    localparam logic [bitSize:0]  LP_FRAME      = (bitSize+1)'(N*N);
    localparam logic [bitSize:0]  LP_FRAME_LAST = (bitSize+1)'(N*N-1);
    localparam logic [PACE_W-1:0] LP_PACE_LAST  = PACE_W'(PACE-1);
    localparam logic [PROC_W-1:0] LP_PROC_LAST  = PROC_W'(PROC_CYCLES-1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PROCESS, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_we;
    logic [pixelWidth-1:0] r_data_out;
    logic [bitSize:0]      r_pix_index;
    logic [bitSize:0]      r_accepted;
    logic [PACE_W-1:0]     r_pace_cnt;
    logic [PROC_W-1:0]     r_proc_cnt;
    logic                  r_busy;
    logic                  r_frame_done;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [pixelWidth-1:0] w_fifo_head;
    logic                  w_start_frame;
    logic                  w_s_ready;
    logic                  w_push;
    logic                  w_slot_end;
    logic                  w_last;
    logic                  w_pop;
    logic                  w_proc_term;

    assign w_start_frame = (r_state == S_IDLE) && i_start;
    assign w_s_ready     = (r_state == S_LOAD) && !w_fifo_full && (r_accepted < LP_FRAME);
    assign w_push        = i_s_valid && w_s_ready;
    assign w_slot_end    = r_we && (r_pace_cnt == '0);
    assign w_last        = w_slot_end && (r_pix_index == LP_FRAME_LAST);
    // A new pixel is taken when nothing is on the bus or a slot is ending mid-frame.
    assign w_pop         = (r_state == S_LOAD) && !w_fifo_empty && (!r_we || (w_slot_end && !w_last));
    assign w_proc_term   = (r_state == S_PROCESS) && (r_proc_cnt == LP_PROC_LAST);

    pixel_stream_loader_fifo #(
        .W     (pixelWidth),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (w_start_frame),
        .i_push     (w_push),
        .i_push_dat (i_s_data),
        .i_pop      (w_pop),
        .o_head     (w_fifo_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start)     w_state_nxt = S_LOAD;
            S_LOAD:    if (w_last)      w_state_nxt = S_PROCESS;
            S_PROCESS: if (w_proc_term) w_state_nxt = S_DONE;
            S_DONE:                     w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_we         <= 1'b0;
            r_data_out   <= '0;
            r_pix_index  <= '0;
            r_accepted   <= '0;
            r_pace_cnt   <= '0;
            r_proc_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_PROCESS);
            r_frame_done <= (w_state_nxt == S_DONE);

            if (r_state == S_PROCESS) r_proc_cnt <= w_proc_term ? '0 : r_proc_cnt + 1'b1;
            else                      r_proc_cnt <= '0;

            if (w_start_frame) begin
                r_we        <= 1'b0;
                r_pix_index <= '0;
                r_accepted  <= '0;
                r_pace_cnt  <= '0;
            end else begin
                if (w_push) r_accepted <= r_accepted + 1'b1;
                if (w_slot_end) r_pix_index <= r_pix_index + 1'b1;
                if (w_pop) begin
                    r_data_out <= w_fifo_head;
                    r_we       <= 1'b1;
                    r_pace_cnt <= LP_PACE_LAST;
                end else if (r_we) begin
                    if (r_pace_cnt == '0) r_we <= 1'b0;
                    else                  r_pace_cnt <= r_pace_cnt - 1'b1;
                end
            end
        end
    end

    assign o_s_ready    = w_s_ready;
    assign o_we         = r_we;
    assign o_data_out   = r_data_out;
    assign o_pix_index  = r_pix_index;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_pixel_stream_loader.sv
// Bench for pixel_stream_loader: queue-based frame model checked every clock plus frame-level timing checks.
module tb_pixel_stream_loader;
    localparam int DEPTH = 4;
    localparam int PACE  = 2;
    localparam int PROC  = 320;
    localparam int FRAME = 64;
    localparam int M_IDLE = 0, M_LOAD = 1, M_PROC = 2, M_DONE = 3;

    logic       clk, rst, start, s_valid;
    logic [7:0] s_data;
    logic       s_ready, we, busy, frame_done;
    logic [7:0] data_out;
    logic [6:0] pix_index;

    pixel_stream_loader #(
        .N(8), .pixelWidth(8), .FIFO_DEPTH(DEPTH), .PACE(PACE), .PROC_CYCLES(PROC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_s_valid(s_valid), .i_s_data(s_data),
        .o_s_ready(s_ready), .o_we(we), .o_data_out(data_out), .o_pix_index(pix_index),
        .o_busy(busy), .o_frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: frame phase, FIFO as a queue, clocks left in the current slot.
    int         m_state, m_acc, m_pix, m_hold, m_proc;
    bit         m_we;
    logic [7:0] m_dout;
    logic [7:0] m_fifo[$];

    function automatic bit m_sready();
        return (m_state == M_LOAD) && (m_fifo.size() < DEPTH) && (m_acc < FRAME);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_acc = 0; m_pix = 0; m_hold = 0; m_proc = 0;
        m_we = 1'b0; m_dout = 8'd0; m_fifo.delete();
    endtask

    task automatic model_step(input bit hs, input bit st, input logic [7:0] d);
        bit ended;
        int pre;
        case (m_state)
            M_IDLE: if (st) begin
                m_state = M_LOAD; m_fifo.delete(); m_acc = 0; m_pix = 0; m_we = 1'b0;
            end
            M_LOAD: begin
                ended = 1'b0;
                pre = m_fifo.size();
                if (m_we) begin
                    m_hold--;
                    if (m_hold == 0) begin m_pix++; ended = 1'b1; end
                end
                if (ended && m_pix == FRAME) begin
                    m_we = 1'b0; m_state = M_PROC; m_proc = 0;
                end else if ((!m_we || ended) && pre > 0) begin
                    m_dout = m_fifo.pop_front(); m_we = 1'b1; m_hold = PACE;
                end else if (ended) begin
                    m_we = 1'b0;
                end
                if (hs) begin m_fifo.push_back(d); m_acc++; end
            end
            M_PROC: begin
                m_proc++;
                if (m_proc == PROC) m_state = M_DONE;
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    int cyc, we_cycles, we_rises, we_fall_cyc, fd_cyc, fd_count, hs_count, first_hs_cyc, first_we_cyc, last_offer;
    bit prev_we;

    task automatic clear_stats();
        we_cycles = 0; we_rises = 0; we_fall_cyc = -1; fd_cyc = -1; fd_count = 0;
        hs_count = 0; first_hs_cyc = -1; first_we_cyc = -1; prev_we = 1'b0;
    endtask

    task automatic tick(output bit hs);
        @(negedge clk);
        chk("s_ready", 32'(s_ready), 32'(m_sready()));
        chk("we", 32'(we), 32'(m_we));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("pix_index", 32'(pix_index), 32'(m_pix));
        chk("busy", 32'(busy), 32'((m_state == M_LOAD) || (m_state == M_PROC)));
        chk("frame_done", 32'(frame_done), 32'(m_state == M_DONE));
        hs = s_valid && m_sready();
        if (we) we_cycles++;
        if (we && !prev_we) begin
            we_rises++;
            if (first_we_cyc < 0) first_we_cyc = cyc;
        end
        if (!we && prev_we) we_fall_cyc = cyc;
        if (frame_done) begin fd_count++; fd_cyc = cyc; end
        if (hs) begin
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            hs_count++;
        end
        prev_we = we;
        @(posedge clk);
        model_step(hs, start, s_data);
        cyc++;
        #1;
    endtask

    // mode 0: always valid, data = index; mode 1: valid every 5th clock; mode 2: random valid/data.
    task automatic run_frame(input int mode, input bit pulse_in_proc, input int stop_pix);
        int offer;
        logic [7:0] pend;
        bit done_seen, finished, hs;
        clear_stats();
        offer = 0; done_seen = 1'b0; finished = 1'b0;
        pend = (mode == 0) ? 8'd0 : 8'($urandom);
        for (int c = 0; c < 3000 && !finished; c++) begin
            start = (c == 0) || (pulse_in_proc && m_state == M_PROC && m_proc == 100);
            case (mode)
                0:       s_valid = (offer < 70);
                1:       s_valid = (offer < 70) && (c % 5 == 0);
                default: s_valid = (offer < 70) && ($urandom_range(0, 9) < 7);
            endcase
            s_data = pend;
            tick(hs);
            if (hs) begin
                offer++;
                pend = (mode == 0) ? 8'(offer) : 8'($urandom);
            end
            if (m_state == M_DONE) done_seen = 1'b1;
            if (stop_pix > 0 && m_pix == stop_pix) finished = 1'b1;
            if (done_seen && m_state == M_IDLE) finished = 1'b1;
        end
        start = 1'b0;
        s_valid = 1'b0;
        last_offer = offer;
        chk("frame_timeout", 32'(finished), 32'd1);
        if (stop_pix == 0) for (int k = 0; k < 8; k++) tick(hs);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({pfx, "_we"}, 32'(we), 32'd0);
        chk({pfx, "_data_out"}, 32'(data_out), 32'd0);
        chk({pfx, "_pix_index"}, 32'(pix_index), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'd0; cyc = 0;
        model_reset();
        clear_stats();
        #1 rst = 1'b1;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Abandon a frame mid-load with an asynchronous reset.
        run_frame(2, 1'b0, 17);
        chk("mid_pix_before_rst", 32'(pix_index), 32'd17);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal frame; upstream offers 70 pixels, only 64 may be taken.
        run_frame(0, 1'b0, 0);
        chk("nom_we_cycles", 32'(we_cycles), 32'd128);
        chk("nom_we_rises", 32'(we_rises), 32'd1);
        chk("nom_first_latency", 32'(first_we_cyc - first_hs_cyc), 32'd2);
        chk("nom_done_after_we_fall", 32'(fd_cyc - we_fall_cyc), 32'(PROC));
        chk("nom_done_pulses", 32'(fd_count), 32'd1);
        chk("nom_accepted", 32'(hs_count), 32'(FRAME));
        chk("extra_offered_taken", 32'(last_offer), 32'(FRAME));
        chk("nom_pix_hold", 32'(pix_index), 32'(FRAME));

        // Underrun: one pixel every 5 clocks, so each pixel is its own we burst.
        run_frame(1, 1'b0, 0);
        chk("under_we_rises", 32'(we_rises), 32'(FRAME));
        chk("under_we_cycles", 32'(we_cycles), 32'(FRAME * PACE));
        chk("under_accepted", 32'(hs_count), 32'(FRAME));
        chk("under_pix", 32'(pix_index), 32'(FRAME));

        // Random valid pattern exercises fill/drain and backpressure.
        run_frame(2, 1'b0, 0);
        chk("rand_accepted", 32'(hs_count), 32'(FRAME));
        chk("rand_we_cycles", 32'(we_cycles), 32'(FRAME * PACE));
        chk("rand_done_pulses", 32'(fd_count), 32'd1);

        // start pulsed during PROCESS must be ignored.
        run_frame(2, 1'b1, 0);
        chk("busy_start_done_pulses", 32'(fd_count), 32'd1);
        chk("busy_start_idle_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
